axil_cmd_master: RTL and testbench

- AXI-Lite initiator engine: accepts read/write commands on a ready/valid push port, queues them in a FIFO and executes them one at a time on an AXI-Lite master port.
- Returns one response per command on a ready/valid response port.
- Used to drive the banzAI power and chip-control register slaves from a local sequencer or test harness, i.e. the requesting end of their AXI-Lite register interface.

---
 rtl/axil_cmd_master_if.sv | 31 +++
 rtl/axil_cmd_master.sv | 147 ++++++++++++++
 tb/tb_axil_cmd_master.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_cmd_master_if.sv
// axil_cmd_master_if: AXI-Lite bus (aw, w, b, ar, r) with initiator/target modports.
interface AXI_LITE #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   logic                  aw_valid, aw_ready;
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic [2:0]            aw_prot;
   logic                  w_valid, w_ready;
   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_WIDTH-1:0] w_strb;
   logic                  b_valid, b_ready;
   logic [1:0]            b_resp;
   logic                  ar_valid, ar_ready;
   logic [ADDR_WIDTH-1:0] ar_addr;
   logic [2:0]            ar_prot;
   logic                  r_valid, r_ready;
   logic [DATA_WIDTH-1:0] r_data;
   logic [1:0]            r_resp;
   modport Master (
      output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
             ar_valid, ar_addr, ar_prot, r_ready,
      input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
   );
   modport Slave (
      input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
             ar_valid, ar_addr, ar_prot, r_ready,
      output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
   );
endinterface

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: queues read/write commands and executes them one at a time as AXI-Lite transactions.
module axil_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic [STRB_WIDTH-1:0] cmd_strb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [1:0]            rsp_resp,
   output logic                  busy,
   AXI_LITE.Master               axi_master
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;
   typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;
   state_t state_q, state_d;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [EW-1:0] mem_d [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PW:0] cnt_q, cnt_d;
   logic wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
   logic [STRB_WIDTH-1:0] strb_q, strb_d;
   logic aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_ready_q, b_ready_d;
   logic ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
   logic rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
   logic [1:0] rsp_resp_q, rsp_resp_d;
   logic push, pop;
   logic [EW-1:0] head;
   assign cmd_ready = cnt_q != (PW+1)'(FIFO_DEPTH);
   assign push = cmd_valid && cmd_ready;
   assign pop = state_q == IDLE && cnt_q != '0;
   assign head = mem_q[rptr_q];
   assign busy = cnt_q != '0 || state_q != IDLE;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_data = rsp_data_q;
   assign rsp_resp = rsp_resp_q;
   assign axi_master.aw_valid = aw_valid_q;
   assign axi_master.aw_addr = addr_q;
   assign axi_master.aw_prot = 3'b000;
   assign axi_master.w_valid = w_valid_q;
   assign axi_master.w_data = data_q;
   assign axi_master.w_strb = strb_q;
   assign axi_master.b_ready = b_ready_q;
   assign axi_master.ar_valid = ar_valid_q;
   assign axi_master.ar_addr = addr_q;
   assign axi_master.ar_prot = 3'b000;
   assign axi_master.r_ready = r_ready_q;
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wptr_q] = {cmd_write, cmd_addr, cmd_data, cmd_strb};
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(pop);
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
   end
   always_comb begin
      state_d = state_q;
      {wr_d, addr_d, data_d, strb_d} = {wr_q, addr_q, data_q, strb_q};
      aw_valid_d = aw_valid_q;
      w_valid_d = w_valid_q;
      b_ready_d = b_ready_q;
      ar_valid_d = ar_valid_q;
      r_ready_d = r_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_data_d = rsp_data_q;
      rsp_resp_d = rsp_resp_q;
      case (state_q)
         IDLE: if (pop) begin
            {wr_d, addr_d, data_d, strb_d} = head;
            state_d = head[EW-1] ? WR : RD_AR;
            aw_valid_d = head[EW-1];
            w_valid_d = head[EW-1];
            ar_valid_d = !head[EW-1];
         end
         WR: begin
            // each valid drops on its own handshake; both low means both done
            aw_valid_d = aw_valid_q && !axi_master.aw_ready;
            w_valid_d = w_valid_q && !axi_master.w_ready;
            if (!aw_valid_d && !w_valid_d) begin
               state_d = WR_B;
               b_ready_d = 1'b1;
            end
         end
         WR_B: if (axi_master.b_valid) begin
            b_ready_d = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            rsp_data_d = '0;
            rsp_resp_d = axi_master.b_resp;
            state_d = RSP;
         end
         RD_AR: if (axi_master.ar_ready) begin
            ar_valid_d = 1'b0;
            r_ready_d = 1'b1;
            state_d = RD_R;
         end
         RD_R: if (axi_master.r_valid) begin
            r_ready_d = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b0;
            rsp_data_d = axi_master.r_data;
            rsp_resp_d = axi_master.r_resp;
            state_d = RSP;
         end
         RSP: if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mem_q <= '{default: '0};
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q <= '0;
         {wr_q, addr_q, data_q, strb_q} <= '0;
         {aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q} <= '0;
         {rsp_valid_q, rsp_write_q, rsp_data_q, rsp_resp_q} <= '0;
      end else begin
         state_q <= state_d;
         mem_q <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q <= cnt_d;
         {wr_q, addr_q, data_q, strb_q} <= {wr_d, addr_d, data_d, strb_d};
         {aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q} <= {aw_valid_d, w_valid_d, b_ready_d, ar_valid_d, r_ready_d};
         {rsp_valid_q, rsp_write_q, rsp_data_q, rsp_resp_q} <= {rsp_valid_d, rsp_write_d, rsp_data_d, rsp_resp_d};
      end
   end
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: random and directed commands against a memory-backed AXI-Lite target; responses scoreboarded in order.
module tb_axil_cmd_master;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_data = '0;
   logic [3:0] cmd_strb = '0;
   logic rsp_valid, rsp_ready, rsp_write, busy;
   logic [31:0] rsp_data;
   logic [1:0] rsp_resp;
   AXI_LITE #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();
   axil_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
      .busy(busy), .axi_master(axi)
   );
   int total = 0, bad = 0;
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   typedef struct packed {logic w; logic [31:0] d; logic [1:0] r;} exp_t;
   exp_t exp_q[$];
   exp_t e;
   logic [31:0] rmem [logic [31:0]];
   logic [31:0] smem [logic [31:0]];
   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
      for (int i = 0; i < 4; i++) if (s[i]) old[8*i +: 8] = d[8*i +: 8];
      return old;
   endfunction
   function automatic bit mapped(logic [31:0] a);
      return a < 32'h100;
   endfunction
   // target model knobs
   bit stall = 0, rnd = 0, hold_rsp = 0, rsp_rnd = 0;
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   int b_count = 0, wr_issued = 0;
   initial begin
      logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rst_s, aw_got, w_got, ar_got;
      logic [31:0] awa, wd, ara, awa_n, wd_n, ara_n, old;
      logic [3:0] ws, ws_n;
      int awc, wc, arc, bc, rc;
      {axi.aw_ready, axi.w_ready, axi.b_valid, axi.ar_ready, axi.r_valid} = '0;
      axi.b_resp = '0; axi.r_resp = '0; axi.r_data = '0;
      {aw_got, w_got, ar_got} = '0; {awc, wc, arc, bc, rc} = '0;
      forever begin
         @(negedge clk);
         rst_s = rst;
         aw_hs = axi.aw_valid && axi.aw_ready; awa_n = axi.aw_addr;
         w_hs = axi.w_valid && axi.w_ready; wd_n = axi.w_data; ws_n = axi.w_strb;
         b_hs = axi.b_valid && axi.b_ready;
         ar_hs = axi.ar_valid && axi.ar_ready; ara_n = axi.ar_addr;
         r_hs = axi.r_valid && axi.r_ready;
         @(posedge clk); #1;
         if (rst_s) begin
            {axi.aw_ready, axi.w_ready, axi.b_valid, axi.ar_ready, axi.r_valid} = '0;
            {aw_got, w_got, ar_got} = '0; {awc, wc, arc, bc, rc} = '0;
         end else begin
            if (aw_hs) begin aw_got = 1; awa = awa_n; end
            if (w_hs) begin w_got = 1; wd = wd_n; ws = ws_n; end
            if (ar_hs) begin ar_got = 1; ara = ara_n; end
            if (b_hs) begin axi.b_valid = 0; b_count++; end
            if (r_hs) axi.r_valid = 0;
            if (rnd) begin
               aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
               ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            end
            if (aw_got && w_got && !axi.b_valid) begin
               bc++;
               if (bc > b_dly && !stall) begin
                  if (mapped(awa)) begin
                     old = smem.exists(awa) ? smem[awa] : 32'h0;
                     smem[awa] = merge(old, wd, ws);
                  end
                  axi.b_valid = 1; axi.b_resp = mapped(awa) ? 2'b00 : 2'b10;
                  {aw_got, w_got} = '0; bc = 0;
               end
            end
            if (ar_got && !axi.r_valid) begin
               rc++;
               if (rc > r_dly && !stall) begin
                  axi.r_valid = 1;
                  axi.r_data = mapped(ara) ? (smem.exists(ara) ? smem[ara] : 32'h0) : (32'hBAD0_0000 ^ ara);
                  axi.r_resp = mapped(ara) ? 2'b00 : 2'b11;
                  ar_got = 0; rc = 0;
               end
            end
            awc = axi.aw_valid ? awc + 1 : 0;
            wc = axi.w_valid ? wc + 1 : 0;
            arc = axi.ar_valid ? arc + 1 : 0;
            axi.aw_ready = !stall && axi.aw_valid && awc > aw_dly;
            axi.w_ready = !stall && axi.w_valid && wc > w_dly;
            axi.ar_ready = !stall && axi.ar_valid && arc > ar_dly;
         end
      end
   end
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         rsp_ready = hold_rsp ? 1'b0 : (rsp_rnd ? $urandom_range(0, 3) != 0 : 1'b1);
      end
   end
   // scoreboard and protocol monitor
   logic p_aw, p_w, p_ar, p_rv, p_rhs;
   logic [31:0] p_awa, p_wd, p_ara;
   logic [3:0] p_ws;
   logic [34:0] p_rsp;
   initial {p_aw, p_w, p_ar, p_rv, p_rhs} = '0;
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("rsp_write", rsp_write, e.w);
               chk("rsp_data", rsp_data, e.d);
               chk("rsp_resp", rsp_resp, e.r);
            end
         end
         if (p_rv && !p_rhs) chk("rsp_stable", {rsp_valid, rsp_write, rsp_data, rsp_resp}, {1'b1, p_rsp});
         if (rsp_valid) chk("quiet_in_rsp", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 0);
         if (axi.b_ready || axi.r_ready)
            chk("ready_excl", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready && axi.r_ready}, 0);
         if (p_aw) chk("aw_hold", {axi.aw_valid, axi.aw_addr}, {1'b1, p_awa});
         if (p_w) chk("w_hold", {axi.w_valid, axi.w_data, axi.w_strb}, {1'b1, p_wd, p_ws});
         if (p_ar) chk("ar_hold", {axi.ar_valid, axi.ar_addr}, {1'b1, p_ara});
      end
      p_aw = !rst && axi.aw_valid && !axi.aw_ready; p_awa = axi.aw_addr;
      p_w = !rst && axi.w_valid && !axi.w_ready; p_wd = axi.w_data; p_ws = axi.w_strb;
      p_ar = !rst && axi.ar_valid && !axi.ar_ready; p_ara = axi.ar_addr;
      p_rv = !rst && rsp_valid; p_rhs = rsp_valid && rsp_ready;
      p_rsp = {rsp_write, rsp_data, rsp_resp};
   end
   task automatic push(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
      int n = 0;
      logic [31:0] old;
      cmd_write = w; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_valid = 1'b1;
      while (!cmd_ready && n < 500) begin @(posedge clk); #1; n++; end
      chk("push_timeout", n >= 500, 0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (w) begin
         wr_issued++;
         if (mapped(a)) begin
            old = rmem.exists(a) ? rmem[a] : 32'h0;
            rmem[a] = merge(old, d, s);
         end
         exp_q.push_back('{1'b1, 32'h0, mapped(a) ? 2'b00 : 2'b10});
      end else if (mapped(a)) exp_q.push_back('{1'b0, rmem.exists(a) ? rmem[a] : 32'h0, 2'b00});
      else exp_q.push_back('{1'b0, 32'hBAD0_0000 ^ a, 2'b11});
   endtask
   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 3000) begin @(posedge clk); #1; n++; end
      chk("drain_timeout", n >= 3000, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("b_count", b_count, wr_issued);
   endtask
   task automatic chk_reset();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp", {rsp_valid, rsp_write, rsp_data, rsp_resp}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_axi_ctl", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 0);
      chk("rst_addr", {axi.aw_addr, axi.ar_addr}, 0);
      chk("rst_wdata", {axi.w_data, axi.w_strb}, 0);
      chk("prot", {axi.aw_prot, axi.ar_prot}, 0);
   endtask
   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk_reset();
      rst = 1'b0;
      push(1, 32'h10, 32'hDEADBEEF, 4'hF);
      drain();
      push(1, 32'h14, 32'h12345678, 4'hF);
      r_dly = 3;
      push(0, 32'h14, 32'h0, 4'h0);
      drain();
      r_dly = 0; aw_dly = 2; w_dly = 0;
      push(1, 32'h18, 32'hA5A5_0F0F, 4'h5);
      push(0, 32'h18, 32'h0, 4'h0);
      drain();
      aw_dly = 0;
      stall = 1;
      for (int i = 0; i < 5; i++) push(i[0], 32'h40 + 32'(i * 4), $urandom, 4'hF);
      chk("full_cmd_ready", cmd_ready, 0);
      chk("full_busy", busy, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("full_hold", cmd_ready, 0);
      stall = 0;
      drain();
      push(0, 32'h200, 32'h0, 4'h0);
      push(1, 32'h20, 32'hCAFEF00D, 4'hC);
      push(0, 32'h20, 32'h0, 4'h0);
      push(1, 32'h204, 32'h1, 4'hF);
      drain();
      hold_rsp = 1;
      push(1, 32'h24, 32'h55AA55AA, 4'hF);
      n = 0;
      while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("rsp_wait_timeout", n >= 100, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("held_rsp_valid", rsp_valid, 1);
      hold_rsp = 0;
      drain();
      rnd = 1; rsp_rnd = 1;
      for (int i = 0; i < 40; i++)
         push(1'($urandom_range(0, 1)), 32'($urandom_range(0, 71)) << 2, $urandom, 4'($urandom_range(0, 15)));
      drain();
      rnd = 0; rsp_rnd = 0; {aw_dly, w_dly, b_dly, ar_dly} = '0; r_dly = 20;
      push(0, 32'h10, 32'h0, 4'h0);
      n = 0;
      while (!axi.r_ready && n < 100) begin @(posedge clk); #1; n++; end
      chk("r_ready_timeout", n >= 100, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset();
      rst = 1'b0;
      exp_q.delete();
      r_dly = 0;
      push(1, 32'h30, 32'h0BADF00D, 4'hF);
      push(0, 32'h30, 32'h0, 4'h0);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
